// File: rtl/frame_scanner.sv
// frame_scanner: streams a BPP-deep frame RAM as RGB565 pixels to an LCD driver (clk/reset/en/mode/start in; read_addr, pixel_rgb, print, busy, initialized, frame_done out)
module frame_scanner #(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int BPP = 1,
  parameter int RAM_LATENCY = 1,
  localparam int NPIX = H_RES * V_RES,
  localparam int AW = $clog2(NPIX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          mode,
  input  logic          start,
  output logic [AW-1:0] read_addr,
  input  logic [BPP-1:0] ram_q,
  output logic [15:0]   pixel_rgb,
  output logic          print,
  input  logic          driver_done,
  input  logic          driver_initialized,
  output logic          initialized,
  output logic          busy,
  output logic          frame_done
);
  typedef enum logic [2:0] {S_RESET, S_WAIT_INIT, S_IDLE, S_FETCH, S_SEND} state_t;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [15:0] rgb_q, rgb_d;
  logic [7:0] g8;
  logic last_px;
  assign g8 = {(8 / BPP){ram_q}};
  assign last_px = ptr_q == LAST;
  assign read_addr = ptr_q;
  assign pixel_rgb = rgb_q;
  assign print = state_q == S_SEND;
  assign busy = state_q == S_FETCH || state_q == S_SEND;
  assign initialized = busy || state_q == S_IDLE;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    wcnt_d = wcnt_q;
    rgb_d = rgb_q;
    frame_done = 1'b0;
    if (en)
      case (state_q)
        S_RESET: state_d = S_WAIT_INIT;
        S_WAIT_INIT: state_d = driver_initialized ? S_IDLE : S_WAIT_INIT;
        S_IDLE: state_d = (mode || start) ? S_FETCH : S_IDLE;
        S_FETCH:
          if (wcnt_q == 2'(RAM_LATENCY - 1)) begin
            state_d = S_SEND;
            wcnt_d = 2'd0;
            rgb_d = {g8[7:3], g8[7:2], g8[7:3]};
          end else
            wcnt_d = wcnt_q + 2'd1;
        S_SEND:
          if (driver_done) begin
            frame_done = last_px;
            ptr_d = last_px ? '0 : ptr_q + 1'b1;
            state_d = (!last_px || mode) ? S_FETCH : S_IDLE;
          end
        default: state_d = S_RESET;
      endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      ptr_q <= '0;
      wcnt_q <= 2'd0;
      rgb_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      wcnt_q <= wcnt_d;
      rgb_q <= rgb_d;
    end
  end
endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: directed table-driven bench for frame_scanner (4x2 frame, RAM latency 2, BPP 1/2/8 instances in lockstep)
module tb_frame_scanner;
  typedef struct {logic ram; logic [15:0] rgb;} px_t;
  typedef struct {logic [1:0] q2; logic [15:0] e2; logic [7:0] q8; logic [15:0] e8;} cv_t;
  logic clk = 0, reset = 0, en = 1, mode = 0, start = 0, drv_init = 0;
  logic auto_ack = 1, man_dd = 0, dd_auto = 0, driver_done, ram1;
  logic [1:0] ram2 = '0;
  logic [7:0] ram8 = '0;
  logic mem [8];
  logic [2:0] addr, addr2, addr8;
  logic [15:0] rgb, rgb2, rgb8;
  logic print, print2, print8, init, init2, init8, busy, busy2, busy8, fd, fd2, fd8;
  int checks = 0, failures = 0, pc = 0, fd_cnt = 0;
  int addr_log[$];
  logic [15:0] rgb_log[$];
  px_t px [8];
  cv_t cv [4];
  assign driver_done = auto_ack ? dd_auto : man_dd;
  always #5 clk = ~clk;
  always_ff @(posedge clk) ram1 <= mem[addr];
  frame_scanner #(.H_RES(4), .V_RES(2), .BPP(1), .RAM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .read_addr(addr), .ram_q(ram1),
    .pixel_rgb(rgb), .print(print), .driver_done(driver_done), .driver_initialized(drv_init),
    .initialized(init), .busy(busy), .frame_done(fd));
  frame_scanner #(.H_RES(4), .V_RES(2), .BPP(2), .RAM_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .read_addr(addr2), .ram_q(ram2),
    .pixel_rgb(rgb2), .print(print2), .driver_done(driver_done), .driver_initialized(drv_init),
    .initialized(init2), .busy(busy2), .frame_done(fd2));
  frame_scanner #(.H_RES(4), .V_RES(2), .BPP(8), .RAM_LATENCY(2)) u8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .read_addr(addr8), .ram_q(ram8),
    .pixel_rgb(rgb8), .print(print8), .driver_done(driver_done), .driver_initialized(drv_init),
    .initialized(init8), .busy(busy8), .frame_done(fd8));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    if (en && print && driver_done) begin
      addr_log.push_back(int'(addr));
      rgb_log.push_back(rgb);
    end
    if (fd) fd_cnt++;
    @(posedge clk);
    #1;
    pc = print ? pc + 1 : 0;
    dd_auto = print && pc >= 3;
    #1;
  endtask
  task automatic clear_logs;
    addr_log.delete();
    rgb_log.delete();
    fd_cnt = 0;
  endtask
  task automatic start_frame;
    start = 1;
    tick;
    start = 0;
    chk("lat_busy", busy, 1);
    chk("lat_print0", print, 0);
    chk("lat_addr", addr, 0);
    tick;
    chk("lat_print1", print, 0);
    tick;
    chk("lat_print2", print, 1);
  endtask
  task automatic run_frame_end;
    int k = 0;
    while (busy && k < 400) begin tick; k++; end
    chk("frame_end_timeout", busy, 0);
  endtask
  task automatic wait_log(input int n);
    int k = 0;
    while (addr_log.size() < n && k < 600) begin tick; k++; end
    chk("wait_log_timeout", addr_log.size() >= n, 1);
  endtask
  task automatic wait_print;
    int k = 0;
    while (!print && k < 50) begin tick; k++; end
    chk("wait_print_timeout", print, 1);
  endtask
  initial begin
    px = '{'{1'b1, 16'hFFFF}, '{1'b0, 16'h0000}, '{1'b1, 16'hFFFF}, '{1'b1, 16'hFFFF},
           '{1'b0, 16'h0000}, '{1'b0, 16'h0000}, '{1'b1, 16'hFFFF}, '{1'b0, 16'h0000}};
    cv = '{'{2'b10, 16'hAD55, 8'h00, 16'h0000}, '{2'b01, 16'h52AA, 8'hFF, 16'hFFFF},
           '{2'b11, 16'hFFFF, 8'h80, 16'h8410}, '{2'b00, 16'h0000, 8'h5A, 16'h5ACB}};
    for (int i = 0; i < 8; i++) mem[i] = px[i].ram;
    #1 reset = 1;
    #2;
    chk("rst_print", print, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init", init, 0);
    chk("rst_fd", fd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rgb", rgb, 0);
    tick;
    reset = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      chk("wait_init", {init, print}, 0);
    end
    drv_init = 1;
    tick;
    tick;
    chk("init_up", init, 1);
    chk("init_idle", busy, 0);
    for (int c = 0; c < 4; c++) begin
      ram2 = cv[c].q2;
      ram8 = cv[c].q8;
      clear_logs();
      start_frame();
      chk("conv_bpp2", rgb2, cv[c].e2);
      chk("conv_bpp8", rgb8, cv[c].e8);
      run_frame_end();
      chk("frame_prints", addr_log.size(), 8);
      for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
        chk("frame_addr", addr_log[i], i);
        chk("frame_rgb", rgb_log[i], px[i].rgb);
      end
      chk("frame_done_cnt", fd_cnt, 1);
      chk("frame_addr_wrap", addr, 0);
      chk("frame_rgb_hold", rgb, px[7].rgb);
      tick;
      tick;
      chk("stay_idle", busy, 0);
    end
    clear_logs();
    mode = 1;
    wait_log(19);
    mode = 0;
    run_frame_end();
    chk("cont_prints", addr_log.size(), 24);
    for (int i = 0; i < 24 && i < addr_log.size(); i++) chk("cont_addr", addr_log[i], i % 8);
    chk("cont_fd_cnt", fd_cnt, 3);
    chk("cont_idle_init", init, 1);
    clear_logs();
    start_frame();
    wait_log(7);
    wait_print();
    chk("en_pre_addr", addr, 7);
    auto_ack = 0;
    man_dd = 0;
    start = 1;
    tick;
    start = 0;
    en = 0;
    for (int i = 0; i < 10; i++) begin
      man_dd = (i == 5);
      #1;
      chk("en0_fd", fd, 0);
      tick;
      chk("en0_print", print, 1);
      chk("en0_addr", addr, 7);
      chk("en0_rgb", rgb, px[7].rgb);
    end
    man_dd = 0;
    en = 1;
    tick;
    chk("en1_print", print, 1);
    chk("en1_addr", addr, 7);
    man_dd = 1;
    #1;
    chk("en1_fd", fd, 1);
    tick;
    man_dd = 0;
    auto_ack = 1;
    chk("en_end_busy", busy, 0);
    chk("en_end_addr", addr, 0);
    for (int i = 0; i < 4; i++) tick;
    chk("start_not_queued", busy, 0);
    chk("en_prints", addr_log.size(), 8);
    chk("en_fd_cnt", fd_cnt, 1);
    clear_logs();
    start_frame();
    wait_log(5);
    wait_print();
    chk("rst_mid_addr", addr, 5);
    drv_init = 0;
    #2 reset = 1;
    #1;
    chk("rstm_print", print, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_init", init, 0);
    chk("rstm_addr", addr, 0);
    chk("rstm_rgb", rgb, 0);
    tick;
    tick;
    reset = 0;
    start = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rstm_wait_init", {init, busy}, 0);
    end
    drv_init = 1;
    clear_logs();
    begin
      int k = 0;
      while (!busy && k < 20) begin tick; k++; end
    end
    start = 0;
    chk("rstm_restart_busy", busy, 1);
    chk("rstm_first_addr", addr, 0);
    run_frame_end();
    chk("rstm_prints", addr_log.size(), 8);
    if (addr_log.size() > 0) chk("rstm_log0", addr_log[0], 0);
    chk("rstm_fd_cnt", fd_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_scanner.md
FRAME_SCANNER -- requirements
Module: frame_scanner

Interface
REQ-001 Parameter H_RES, default 320: pixels per line.
REQ-002 Parameter V_RES, default 240: lines per frame.
REQ-003 Parameter BPP, default 1: frame RAM bits per pixel; legal values are 1, 2, 4 and 8.
REQ-004 Parameter RAM_LATENCY, default 1: read latency of the frame RAM, in cycles (1..4).
REQ-005 Derived constants: NPIX = H_RES*V_RES; AW = clog2(NPIX).
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 en  in  1  global enable; 0 freezes the FSM, counters and all registered outputs.
REQ-009 mode  in  1  1 = continuous refresh; 0 = single frame per start pulse.
REQ-010 start  in  1  single-frame trigger; sampled only in IDLE when mode=0.
REQ-011 read_addr  out  AW  frame RAM read address.
REQ-012 ram_q  in  BPP  frame RAM read data.
REQ-013 pixel_rgb  out  16  RGB565 pixel sent to the LCD driver.
REQ-014 print  out  1  pixel request to the LCD driver.
REQ-015 driver_done  in  1  driver acknowledge of the current pixel.
REQ-016 driver_initialized  in  1  the LCD driver has finished its init sequence.
REQ-017 initialized  out  1  high in IDLE, FETCH and SEND.
REQ-018 busy  out  1  high in FETCH and SEND.
REQ-019 frame_done  out  1  one-cycle pulse when the last pixel of a frame is acknowledged.

Function
REQ-020 The block SHALL be built around an FSM with states RESET, WAIT_INIT, IDLE, FETCH and SEND, and a pixel pointer ptr of width AW with range 0..NPIX-1; read_addr = ptr.
REQ-021 The FSM SHALL go from RESET to WAIT_INIT unconditionally.
REQ-022 The FSM SHALL stay in WAIT_INIT until driver_initialized=1, then go to IDLE; driver_initialized SHALL be ignored in every other state.
REQ-023 IDLE SHALL go to FETCH when mode=1, or when mode=0 and start=1; otherwise it stays in IDLE.
REQ-024 FETCH SHALL last exactly RAM_LATENCY cycles, counted by a wait counter, and then go to SEND.
REQ-025 On the edge that leaves FETCH, pixel_rgb SHALL capture conv(ram_q) and SHALL then hold that value until the next FETCH completes.
REQ-026 conv: for BPP=1, 0 -> 16'h0000 and 1 -> 16'hFFFF.
REQ-027 conv: for BPP>1, g8 is ram_q bit-replicated to 8 bits, and pixel_rgb = {g8[7:3], g8[7:2], g8[7:3]} (so BPP=2 with ram_q=2'b10 gives 16'hAD55).
REQ-028 print SHALL equal (state==SEND) and SHALL stay high until driver_done is sampled high in SEND.
REQ-029 driver_done sampled outside SEND SHALL be ignored.
REQ-030 In SEND, when driver_done=1 and ptr<NPIX-1, the block SHALL set ptr to ptr+1 and go to FETCH.
REQ-031 In SEND, when driver_done=1 and ptr=NPIX-1, the block SHALL set ptr to 0 (wrap), pulse frame_done for that one cycle, and go to FETCH if mode=1 or to IDLE if mode=0.
REQ-032 mode SHALL be sampled only in IDLE and at the frame-end decision of REQ-031; a mid-frame change of mode SHALL NOT abort the current frame.
REQ-033 start asserted while not in IDLE SHALL be ignored; it is not queued.
REQ-034 While en=0, state, ptr, the wait counter, pixel_rgb, print and busy SHALL hold their values, and frame_done SHALL be 0.
REQ-035 Latency: if start is sampled at edge k in IDLE, print SHALL first be high after edge k+RAM_LATENCY, with read_addr valid from edge k.

Reset
REQ-036 Asserting reset SHALL immediately, without waiting for a clock edge, set state=RESET, ptr=0, the wait counter to 0, pixel_rgb=16'h0000, and print, busy, initialized and frame_done all to 0.
REQ-037 Reset asserted in the middle of a frame SHALL drop print combinationally; after release, scanning SHALL restart from ptr=0 only after driver_initialized is high again.

Verification
REQ-038 Init: hold driver_initialized=0 for 50 cycles -> initialized=0 and print=0 throughout; raise it -> IDLE within 2 cycles and initialized=1.
REQ-039 Single frame, H_RES=4, V_RES=2, BPP=1, RAM_LATENCY=2, driver acking 3 cycles after print -> exactly 8 prints at addresses 0..7, one frame_done pulse, return to IDLE, read_addr=0.
REQ-040 Continuous mode -> address sequence 0..7,0,1,... and one frame_done per frame; switching mode to 0 mid-frame -> the frame completes, then IDLE.
REQ-041 BPP=2, ram_q=2'b10 -> pixel_rgb=16'hAD55; BPP=8, ram_q=8'h00 -> 16'h0000.
REQ-042 Pull en low for 10 cycles during SEND -> print stays high and ptr is unchanged; driver_done pulsed while en=0 is not consumed.
REQ-043 Assert reset at pixel 5 of a frame -> print=0 in the same cycle; after release with driver_initialized=1 -> the first fetch is at address 0.
